// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection lamp bus, used by both the traffic
// light controller and the independent safety monitor.
//   - Lamp bus order: {N,S,E,W}, each direction {R,G,Y}, 1 = lamp lit.
//   - The five legal lamp patterns (INIT and phases P1..P4).
//   - Phase encodings, fault codes and monitor FSM states.
//   - Helpers: pattern decoder, conflict detector, legal successor lookup.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int LED_W = 12;

    // Bit offset of each direction's {R,G,Y} triple inside the lamp bus
    localparam int DIR_N = 9;
    localparam int DIR_S = 6;
    localparam int DIR_E = 3;
    localparam int DIR_W = 0;

    // Lamp offset inside a triple
    localparam int LAMP_G = 1;
    localparam int LAMP_Y = 0;

    //                                         N    S    E    W
    localparam logic [LED_W-1:0] PAT_INIT = 12'b111_111_111_111;
    localparam logic [LED_W-1:0] PAT_P1   = 12'b100_100_010_010;
    localparam logic [LED_W-1:0] PAT_P2   = 12'b100_100_001_001;
    localparam logic [LED_W-1:0] PAT_P3   = 12'b010_010_100_100;
    localparam logic [LED_W-1:0] PAT_P4   = 12'b001_001_100_100;

    typedef enum logic [2:0] {
        PH_UNKNOWN = 3'd0,
        PH_INIT    = 3'd1,
        PH_P1      = 3'd2,
        PH_P2      = 3'd3,
        PH_P3      = 3'd4,
        PH_P4      = 3'd5,
        PH_ILLEGAL = 3'd6
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_CONFLICT = 3'd1,
        FC_PATTERN  = 3'd2,
        FC_SEQUENCE = 3'd3,
        FC_SHORT    = 3'd4,
        FC_LONG     = 3'd5
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_e;

    function automatic phase_e decode_phase(input logic [LED_W-1:0] led);
        case (led)
            PAT_INIT: return PH_INIT;
            PAT_P1:   return PH_P1;
            PAT_P2:   return PH_P2;
            PAT_P3:   return PH_P3;
            PAT_P4:   return PH_P4;
            default:  return PH_ILLEGAL;
        endcase
    endfunction

    // Crossing traffic both allowed to move. INIT lights everything on
    // purpose and is not a conflict.
    function automatic logic lamp_conflict(input logic [LED_W-1:0] led);
        logic ns_go;
        logic ew_go;
        ns_go = led[DIR_N+LAMP_G] | led[DIR_N+LAMP_Y] | led[DIR_S+LAMP_G] | led[DIR_S+LAMP_Y];
        ew_go = led[DIR_E+LAMP_G] | led[DIR_E+LAMP_Y] | led[DIR_W+LAMP_G] | led[DIR_W+LAMP_Y];
        return ns_go && ew_go && (led != PAT_INIT);
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_INIT: return PH_P1;
            PH_P1:   return PH_P2;
            PH_P2:   return PH_P3;
            PH_P3:   return PH_P4;
            PH_P4:   return PH_P1;
            default: return PH_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running 1 s tick divider: counts 0..CLK_HZ-1 and pulses o_tick for
// the single cycle in which the count equals CLK_HZ-1.
//   clk    : clock
//   rst    : asynchronous active-high reset (count returns to 0)
//   o_tick : one-cycle pulse once every CLK_HZ cycles
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int               CNT_W   = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
// Independent safety monitor for the four-way lamp bus. Registers the lamp
// vector, decodes it into a phase, times each phase in whole seconds and
// checks pattern, phase order and phase duration. The first violation is
// latched until clr_fault.
//   clk          : clock
//   rst          : asynchronous active-high reset
//   i_led        : lamp bus {N,S,E,W}, each {R,G,Y}
//   clr_fault    : level, clears a latched fault
//   o_fault      : fault latched
//   o_fault_code : 0 none, 1 conflict, 2 pattern, 3 sequence, 4 short, 5 long
//   o_phase      : 0 unknown, 1 INIT, 2..5 P1..P4, 6 illegal
//   o_phase_sec  : whole seconds in current phase, saturating at 63
//   o_tick       : 1 s pulse
// -----------------------------------------------------------------------------
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int GREEN_S  = 30,
    parameter int YELLOW_S = 5,
    parameter int TOL_S    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] i_led,
    input  logic             clr_fault,
    output logic             o_fault,
    output logic [2:0]       o_fault_code,
    output logic [2:0]       o_phase,
    output logic [5:0]       o_phase_sec,
    output logic             o_tick
);

    logic [LED_W-1:0] led_q;
    logic             led_vld_q;   // led_q holds a real sample, not the reset value
    phase_e           phase_q;
    phase_e           phase_d;
    logic [5:0]       sec_q;
    logic [5:0]       sec_d;
    mon_state_e       state_q;
    logic             first_q;     // current phase was entered from IDLE
    logic             fault_q;
    fault_code_e      code_q;

    logic             tick;
    logic             conflict;
    logic             phase_chg;
    logic             checked;
    int               elapsed;
    int               expect_s;
    fault_code_e      viol;

    function automatic int expected_s(input phase_e ph);
        return (ph == PH_P1 || ph == PH_P3) ? GREEN_S : YELLOW_S;
    endfunction

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .o_tick (tick)
    );

    always_comb begin
        phase_d   = led_vld_q ? decode_phase(led_q) : PH_UNKNOWN;
        conflict  = led_vld_q && lamp_conflict(led_q);
        phase_chg = (phase_d != phase_q);
        checked   = phase_q inside {PH_P1, PH_P2, PH_P3, PH_P4};
        elapsed   = int'(sec_q);
        expect_s  = expected_s(phase_q);

        if (phase_chg) begin
            sec_d = '0;
        end else if (tick && sec_q != '1) begin
            sec_d = sec_q + 6'd1;
        end else begin
            sec_d = sec_q;
        end

        // Checks are ordered so the lowest code wins when several hit at once
        viol = FC_NONE;
        if (conflict) begin
            viol = FC_CONFLICT;
        end else if (phase_d == PH_ILLEGAL) begin
            viol = FC_PATTERN;
        end else if (state_q == ST_RUN) begin
            if (phase_chg) begin
                if (phase_d != next_phase(phase_q)) begin
                    viol = FC_SEQUENCE;
                end else if (checked && !first_q && elapsed < expect_s - TOL_S) begin
                    viol = FC_SHORT;
                end
            end else if (checked && elapsed > expect_s + TOL_S) begin
                // Overrun is flagged as soon as it happens, not at phase end
                viol = FC_LONG;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            led_vld_q <= 1'b0;
            phase_q   <= PH_UNKNOWN;
            sec_q     <= '0;
        end else begin
            led_q     <= i_led;
            led_vld_q <= 1'b1;
            phase_q   <= phase_d;
            sec_q     <= sec_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (viol != FC_NONE) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= viol;
                    end else if (phase_d == PH_INIT || phase_d == PH_P1) begin
                        state_q <= ST_RUN;
                        first_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (viol != FC_NONE) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= viol;
                    end else if (phase_chg) begin
                        first_q <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    // Clear takes precedence over any violation seen this cycle
                    if (clr_fault) begin
                        state_q <= ST_IDLE;
                        fault_q <= 1'b0;
                        code_q  <= FC_NONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_fault      = fault_q;
    assign o_fault_code = code_q;
    assign o_phase      = phase_q;
    assign o_phase_sec  = sec_q;
    assign o_tick       = tick;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
// Directed scenarios followed by randomized phase sequences. Expected outputs
// come from a reference model that works on edge counts: phases are looked up
// in a pattern table, seconds are derived arithmetically from the edge at
// which the phase began, and faults from the phase rules.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

    localparam int CLK_HZ   = 10;
    localparam int GREEN_S  = 30;
    localparam int YELLOW_S = 5;
    localparam int TOL_S    = 1;

    localparam logic [11:0] PAT_INIT = 12'b111_111_111_111;
    localparam logic [11:0] PAT_P1   = 12'b100_100_010_010;
    localparam logic [11:0] PAT_P2   = 12'b100_100_001_001;
    localparam logic [11:0] PAT_P3   = 12'b010_010_100_100;
    localparam logic [11:0] PAT_P4   = 12'b001_001_100_100;
    localparam logic [11:0] PAT_CONF = 12'b100_010_010_010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] i_led = '0;
    logic        clr_fault = 1'b0;
    logic        o_fault;
    logic [2:0]  o_fault_code;
    logic [2:0]  o_phase;
    logic [5:0]  o_phase_sec;
    logic        o_tick;

    int errors = 0;
    int checks = 0;

    logic [11:0] pats [1:5] = '{PAT_INIT, PAT_P1, PAT_P2, PAT_P3, PAT_P4};

    // Reference model state (phase numbers follow the o_phase encoding)
    int          m_e;       // edges since reset release
    logic [11:0] m_led;     // lamp word sampled at the previous edge
    int          m_ph;
    int          m_sec;
    int          m_seg;     // edge at which the current phase began
    int          m_code;
    bit          m_watch;
    bit          m_first;

    traffic_light_monitor #(
        .CLK_HZ   (CLK_HZ),
        .GREEN_S  (GREEN_S),
        .YELLOW_S (YELLOW_S),
        .TOL_S    (TOL_S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_led        (i_led),
        .clr_fault    (clr_fault),
        .o_fault      (o_fault),
        .o_fault_code (o_fault_code),
        .o_phase      (o_phase),
        .o_phase_sec  (o_phase_sec),
        .o_tick       (o_tick)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [11:0] v);
        for (int p = 1; p <= 5; p++) begin
            if (v == pats[p]) return p;
        end
        return 6;
    endfunction

    function automatic bit conflict(input logic [11:0] v);
        bit ns;
        bit ew;
        ns = v[10] | v[9] | v[7] | v[6];
        ew = v[4]  | v[3] | v[1] | v[0];
        return ns && ew && (v != PAT_INIT);
    endfunction

    function automatic int succ(input int p);
        return (p == 5) ? 2 : p + 1;
    endfunction

    function automatic int exp_s(input int p);
        return (p == 2 || p == 4) ? GREEN_S : YELLOW_S;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_e = 0; m_led = '0; m_ph = 0; m_sec = 0; m_seg = 0;
        m_code = 0; m_watch = 0; m_first = 0;
    endtask

    task automatic model_edge(input logic [11:0] led_s, input logic clr_s);
        int  np;
        int  op;
        int  v;
        bit  cf;
        m_e++;
        np = (m_e >= 2) ? decode(m_led) : 0;
        cf = (m_e >= 2) && conflict(m_led);
        op = m_ph;
        v  = 0;
        if (cf) v = 1;
        else if (np == 6) v = 2;
        else if (m_watch) begin
            if (np != op) begin
                if (np != succ(op)) v = 3;
                else if (op >= 2 && !m_first && m_sec < exp_s(op) - TOL_S) v = 4;
            end else if (op >= 2 && m_sec > exp_s(op) + TOL_S) v = 5;
        end
        if (m_code != 0) begin
            if (clr_s) m_code = 0;
        end else if (v != 0) begin
            m_code  = v;
            m_watch = 0;
        end else if (!m_watch) begin
            if (np == 1 || np == 2) begin
                m_watch = 1;
                m_first = 1;
            end
        end else if (np != op) begin
            m_first = 0;
        end
        if (np != op) m_seg = m_e;
        m_ph  = np;
        m_sec = (m_e / CLK_HZ) - (m_seg / CLK_HZ);
        if (m_sec > 63) m_sec = 63;
        m_led = led_s;
    endtask

    task automatic cyc(input logic [11:0] led, input logic clr);
        i_led     = led;
        clr_fault = clr;
        @(posedge clk);
        #1;
        model_edge(led, clr);
        check("phase", 32'(o_phase), m_ph);
        check("sec", 32'(o_phase_sec), m_sec);
        check("tick", 32'(o_tick), ((m_e % CLK_HZ) == CLK_HZ - 1) ? 1 : 0);
        check("fault", 32'(o_fault), (m_code != 0) ? 1 : 0);
        check("code", 32'(o_fault_code), m_code);
    endtask

    task automatic hold(input logic [11:0] led, input int n);
        for (int i = 0; i < n; i++) cyc(led, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fault"}, 32'(o_fault), 0);
        check({tag, "_code"},  32'(o_fault_code), 0);
        check({tag, "_phase"}, 32'(o_phase), 0);
        check({tag, "_sec"},   32'(o_phase_sec), 0);
        check({tag, "_tick"},  32'(o_tick), 0);
    endtask

    initial begin
        int          found;
        int          n_tick;
        int          sel;
        int          dur;
        int          stim_p;
        logic [11:0] w;

        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Two full legal cycles with sub-second jitter
        hold(PAT_INIT, 20);
        for (int r = 0; r < 2; r++) begin
            hold(PAT_P1, CLK_HZ * GREEN_S  + int'($urandom_range(0, 4)));
            hold(PAT_P2, CLK_HZ * YELLOW_S + int'($urandom_range(0, 4)));
            hold(PAT_P3, CLK_HZ * GREEN_S  + int'($urandom_range(0, 4)));
            hold(PAT_P4, CLK_HZ * YELLOW_S + int'($urandom_range(0, 4)));
        end
        check("legal_fault", 32'(o_fault), 0);

        // Conflict: fault two edges after the input changes
        hold(PAT_P1, 100);
        cyc(PAT_CONF, 1'b0);
        check("conf_edge1", 32'(o_fault), 0);
        cyc(PAT_CONF, 1'b0);
        check("conf_edge2", 32'(o_fault), 1);
        check("conf_code", 32'(o_fault_code), 1);
        hold(PAT_CONF, 5);

        // Clear wins over a violation present in the same cycle
        cyc(PAT_P1, 1'b1);
        check("clr_code", 32'(o_fault_code), 0);
        hold(PAT_P1, 30);
        hold(12'h000, 3);
        check("pattern_code", 32'(o_fault_code), 2);

        // After clear, P2/P3 are ignored until P1; first P1 is only 8 s
        cyc(PAT_P2, 1'b1);
        hold(PAT_P2, 60);
        hold(PAT_P3, 40);
        check("idle_ignore", 32'(o_fault), 0);
        hold(PAT_P1, 80);
        hold(PAT_P2, 20);
        check("first_exempt", 32'(o_fault), 0);
        hold(PAT_P2, 30);
        hold(PAT_P3, 300);
        hold(PAT_P4, 50);
        hold(PAT_P1, 100);
        hold(PAT_P3, 3);
        check("seq_code", 32'(o_fault_code), 3);

        // P1 held 25 s, not first
        cyc(PAT_INIT, 1'b1);
        hold(PAT_INIT, 20);
        hold(PAT_P1, 250);
        hold(PAT_P2, 3);
        check("short_code", 32'(o_fault_code), 4);

        // P2 overrun flagged while still in P2
        cyc(PAT_INIT, 1'b1);
        hold(PAT_INIT, 10);
        hold(PAT_P1, 300);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            cyc(PAT_P2, 1'b0);
            found = (o_fault === 1'b1) ? 1 : 0;
        end
        check("long_seen", found, 1);
        check("long_code", 32'(o_fault_code), 5);
        check("long_phase", 32'(o_phase), 3);
        check("long_sec", 32'(o_phase_sec), 7);

        // Conflict and illegal sequence together
        cyc(PAT_INIT, 1'b1);
        hold(PAT_INIT, 10);
        hold(PAT_P1, 53);
        hold(PAT_CONF, 2);
        check("conf_seq_code", 32'(o_fault_code), 1);

        // Reset while in FAULT, mid-second
        hold(PAT_CONF, 3);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_tick = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(PAT_P1, 1'b0);
            if (n_tick < 0 && o_tick === 1'b1) n_tick = i;
        end
        check("tick_after_rst", n_tick, CLK_HZ - 1);

        // Randomized phase sequences with duration jitter and lamp noise
        stim_p = 1;
        cyc(PAT_INIT, (m_code != 0));
        hold(PAT_INIT, 10);
        for (int s = 0; s < 40; s++) begin
            sel = int'($urandom_range(0, 9));
            if (m_code != 0) cyc(pats[stim_p], 1'b1);
            if (sel < 7) begin
                stim_p = succ(stim_p);
                if (stim_p == 2 || stim_p == 4)
                    dur = CLK_HZ * GREEN_S - 15 + int'($urandom_range(0, 30));
                else
                    dur = CLK_HZ * YELLOW_S - 15 + int'($urandom_range(0, 30));
                hold(pats[stim_p], dur);
            end else if (sel == 7) begin
                stim_p = int'($urandom_range(1, 5));
                hold(pats[stim_p], int'($urandom_range(5, 60)));
            end else begin
                w = 12'($urandom);
                hold(w, int'($urandom_range(1, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
